// File: rtl/record_sequencer_if.sv
// Handshake/result bundle between the record sequencer and its host.
// Host side drives arm/abort/stops/reads; sequencer side reports status.
interface record_sequencer_if #(
    parameter int N_BUF = 6,
    parameter int TS_W  = 16
);
    logic              arm;
    logic              abort;
    logic [TS_W-1:0]   timeout_cycles;
    logic [N_BUF-1:0]  stop_pulse;
    logic              start_rec;
    logic              busy;
    logic              done;
    logic              timed_out;
    logic [N_BUF-1:0]  hit_mask;
    logic [2:0]        hit_count;
    logic [2:0]        rd_addr;
    logic [TS_W-1:0]   rd_data;
    logic              irq;
    logic              irq_ack;

    modport master (
        output arm, abort, timeout_cycles, stop_pulse, rd_addr, irq_ack,
        input  start_rec, busy, done, timed_out, hit_mask, hit_count,
        input  rd_data, irq
    );

    modport slave (
        input  arm, abort, timeout_cycles, stop_pulse, rd_addr, irq_ack,
        output start_rec, busy, done, timed_out, hit_mask, hit_count,
        output rd_data, irq
    );
endinterface

// File: rtl/record_sequencer.sv
// Stop-event timestamp sequencer: arm, capture one-hot stops, finish on full/timeout/abort.
// Optional completion interrupt enabled by RECORD_SEQUENCER_IRQ_EN.
module record_sequencer #(
    parameter int N_BUF = 6,
    parameter int TS_W  = 16
) (
    input logic clk,
    input logic reset,
    record_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, ACQ, DONE} state_e;

    state_e            state_q, state_d;
    logic [TS_W-1:0]   elapsed_q, elapsed_d;
    logic [TS_W-1:0]   ts_q [N_BUF];
    logic [TS_W-1:0]   ts_d [N_BUF];
    logic [N_BUF-1:0]  hit_mask_q, hit_mask_d;
    logic [2:0]        hit_count_q, hit_count_d;
    logic              timed_out_q, timed_out_d;
    logic [TS_W-1:0]   rd_data_q, rd_data_d;
    logic [N_BUF-1:0]  new_hits;
    logic [N_BUF-1:0]  full_mask;
    logic [3:0]        new_cnt;
    logic [3:0]        sum_cnt;

    always_comb begin
        state_d     = state_q;
        elapsed_d   = elapsed_q;
        ts_d        = ts_q;
        hit_mask_d  = hit_mask_q;
        hit_count_d = hit_count_q;
        timed_out_d = timed_out_q;
        rd_data_d   = '0;
        new_hits    = bus.stop_pulse & ~hit_mask_q;
        full_mask   = hit_mask_q | new_hits;
        new_cnt     = '0;
        for (int k = 0; k < N_BUF; k++) begin
            new_cnt = new_cnt + 4'(new_hits[k]);
        end
        sum_cnt = {1'b0, hit_count_q} + new_cnt;

        unique case (state_q)
            IDLE: begin
                if (bus.arm) state_d = START;
            end
            START: begin
                elapsed_d   = '0;
                hit_mask_d  = '0;
                hit_count_d = '0;
                timed_out_d = 1'b0;
                for (int k = 0; k < N_BUF; k++) ts_d[k] = '0;
                state_d = bus.abort ? DONE : ACQ;
            end
            ACQ: begin
                if (bus.abort) begin
                    state_d = DONE;
                end else begin
                    if (!(&elapsed_q)) elapsed_d = elapsed_q + TS_W'(1);
                    hit_mask_d = full_mask;
                    if (sum_cnt > 4'(N_BUF)) hit_count_d = 3'(N_BUF);
                    else                     hit_count_d = sum_cnt[2:0];
                    for (int k = 0; k < N_BUF; k++) begin
                        if (new_hits[k]) ts_d[k] = elapsed_q;
                    end
                    // Completion takes priority over a coincident timeout.
                    if (&full_mask) begin
                        state_d = DONE;
                    end else if (bus.timeout_cycles != '0 &&
                                 elapsed_q == bus.timeout_cycles - TS_W'(1)) begin
                        state_d     = DONE;
                        timed_out_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.arm) state_d = START;
            end
        endcase

        for (int k = 0; k < N_BUF; k++) begin
            if (bus.rd_addr == 3'(k)) rd_data_d = ts_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            elapsed_q   <= '0;
            hit_mask_q  <= '0;
            hit_count_q <= '0;
            timed_out_q <= 1'b0;
            rd_data_q   <= '0;
            for (int k = 0; k < N_BUF; k++) ts_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            elapsed_q   <= elapsed_d;
            hit_mask_q  <= hit_mask_d;
            hit_count_q <= hit_count_d;
            timed_out_q <= timed_out_d;
            rd_data_q   <= rd_data_d;
            for (int k = 0; k < N_BUF; k++) ts_q[k] <= ts_d[k];
        end
    end

    assign bus.start_rec = (state_q == START);
    assign bus.busy      = (state_q == START) || (state_q == ACQ);
    assign bus.done      = (state_q == DONE);
    assign bus.timed_out = timed_out_q;
    assign bus.hit_mask  = hit_mask_q;
    assign bus.hit_count = hit_count_q;
    assign bus.rd_data   = rd_data_q;

`ifdef RECORD_SEQUENCER_IRQ_EN
    logic irq_q, irq_d;
    logic irq_set;

    // Raised together with done; a coincident ack loses to the new event.
    always_comb begin
        irq_set = (state_d == DONE) && (state_q != DONE);
        irq_d   = irq_q;
        if (bus.irq_ack) irq_d = 1'b0;
        if (irq_set)     irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign bus.irq = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = bus.irq_ack;
    assign bus.irq        = 1'b0;
`endif
endmodule

// File: tb/tb_record_sequencer.sv
// Randomized and directed checks of record_sequencer against
// a cycle-indexed acquisition model.
module tb_record_sequencer;
    localparam int N = 6;
    localparam int W = 16;
`ifdef RECORD_SEQUENCER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    logic [N-1:0] sched [0:255];
    int           abort_at;
    int           to_val;

    record_sequencer_if #(.N_BUF(N), .TS_W(W)) bus ();

    record_sequencer #(.N_BUF(N), .TS_W(W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 256; i++) sched[i] = '0;
        abort_at = -1;
        to_val   = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start_rec"}, 32'(bus.start_rec), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_timed_out"}, 32'(bus.timed_out), 0);
        chk({tag, "_hit_mask"}, 32'(bus.hit_mask), 0);
        chk({tag, "_hit_count"}, 32'(bus.hit_count), 0);
        chk({tag, "_rd_data"}, 32'(bus.rd_data), 0);
        chk({tag, "_irq"}, 32'(bus.irq), 0);
    endtask

    task automatic run_acq(input string tag, input bit noise);
        int   e_end;
        bit   e_to;
        logic [N-1:0] e_mask;
        int   e_cnt;
        int   e_ts [N];
        e_end  = -1;
        e_to   = 1'b0;
        e_mask = '0;
        e_cnt  = 0;
        for (int k = 0; k < N; k++) e_ts[k] = 0;
        if (abort_at < 0 && to_val == 0) abort_at = 255;
        // Model: walk ACQ cycles applying abort, capture, full, timeout.
        for (int c = 0; c < 256 && e_end < 0; c++) begin
            if (c == abort_at) begin
                e_end = c;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (sched[c][k] && !e_mask[k]) begin
                        e_mask[k] = 1'b1;
                        e_ts[k]   = c;
                        e_cnt++;
                    end
                end
                if (e_mask == '1) e_end = c;
                else if (to_val != 0 && c == to_val - 1) begin
                    e_end = c;
                    e_to  = 1'b1;
                end
            end
        end

        bus.timeout_cycles = W'(to_val);
        @(negedge clk);
        bus.arm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        chk({tag, "_start_rec"}, 32'(bus.start_rec), 1);
        chk({tag, "_start_busy"}, 32'(bus.busy), 1);
        chk({tag, "_start_done"}, 32'(bus.done), 0);
        for (int c = 0; c <= e_end; c++) begin
            @(negedge clk);
            chk({tag, "_acq_busy"}, 32'(bus.busy), 1);
            if (c == 0) chk({tag, "_one_pulse"}, 32'(bus.start_rec), 0);
            bus.stop_pulse = sched[c];
            bus.abort      = (c == abort_at);
            bus.arm        = noise ? 1'($urandom) : 1'b0;
        end
        @(negedge clk);
        bus.stop_pulse = '0;
        bus.abort      = 1'b0;
        bus.arm        = 1'b0;
        chk({tag, "_done"}, 32'(bus.done), 1);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_timed_out"}, 32'(bus.timed_out), 32'(e_to));
        chk({tag, "_hit_mask"}, 32'(bus.hit_mask), 32'(e_mask));
        chk({tag, "_hit_count"}, 32'(bus.hit_count), 32'(e_cnt));
        chk({tag, "_irq"}, 32'(bus.irq), 32'(IRQ_ON));

        bus.stop_pulse = '1;
        @(negedge clk);
        bus.stop_pulse = '0;
        chk({tag, "_done_hold"}, 32'(bus.hit_mask), 32'(e_mask));
        for (int k = 0; k < 8; k++) begin
            bus.rd_addr = 3'(k);
            @(negedge clk);
            chk($sformatf("%s_ts%0d", tag, k), 32'(bus.rd_data),
                k < N ? 32'(e_ts[k]) : 0);
        end
        chk({tag, "_irq_held"}, 32'(bus.irq), 32'(IRQ_ON));
        bus.irq_ack = 1'b1;
        @(negedge clk);
        bus.irq_ack = 1'b0;
        chk({tag, "_irq_ack"}, 32'(bus.irq), 0);
        chk({tag, "_still_done"}, 32'(bus.done), 1);
    endtask

    initial begin
        bus.arm            = 1'b0;
        bus.abort          = 1'b0;
        bus.timeout_cycles = '0;
        bus.stop_pulse     = '0;
        bus.rd_addr        = '0;
        bus.irq_ack        = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        bus.stop_pulse = '1;
        @(negedge clk);
        bus.stop_pulse = '0;
        chk("idle_stop_mask", 32'(bus.hit_mask), 0);
        chk("idle_busy", 32'(bus.busy), 0);

        // Walking stops, one per channel.
        clear_sched();
        for (int k = 0; k < N; k++) sched[3 + 2 * k] = N'(1 << k);
        run_acq("walk", 1'b0);

        // Timeout with two captures.
        clear_sched();
        to_val   = 20;
        sched[2] = 6'h01;
        sched[5] = 6'h04;
        run_acq("tmo", 1'b0);

        // Duplicate stop plus multi-bit stop; abort closes it.
        clear_sched();
        sched[2] = 6'h01;
        sched[4] = 6'h01;
        sched[6] = 6'h06;
        abort_at = 9;
        run_acq("dup", 1'b1);

        // Abort with coincident stop discards that capture.
        clear_sched();
        sched[1] = 6'h01;
        sched[4] = 6'h02;
        abort_at = 4;
        run_acq("abort", 1'b0);

        // Final capture coincides with timeout: completion wins.
        clear_sched();
        to_val   = 8;
        sched[0] = 6'h0F;
        sched[7] = 6'h30;
        run_acq("race", 1'b0);

        // Reset during acquisition.
        clear_sched();
        bus.timeout_cycles = '0;
        @(negedge clk);
        bus.arm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.stop_pulse = (c == 1) ? 6'h01 : '0;
        end
        bus.stop_pulse = '0;
        bus.rd_addr    = 3'd0;
        chk("pre_reset_mask", 32'(bus.hit_mask), 1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("mid_reset");
        reset = 1'b0;

        for (int t = 0; t < 12; t++) begin
            clear_sched();
            to_val = $urandom_range(0, 40);
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 3) == 0) sched[c] = N'($urandom);
            end
            if ($urandom_range(0, 2) == 0) abort_at = $urandom_range(0, 45);
            if (to_val == 0 && abort_at < 0) abort_at = 50;
            run_acq($sformatf("rnd%0d", t), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
